// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with per-source result FIFOs
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int ID_WIDTH   = 4,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*ID_WIDTH-1:0] src_id,
    input  logic [NUM_SRC*XLEN-1:0]     src_val,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        cdb_valid,
    output logic [ID_WIDTH-1:0]         cdb_id,
    output logic [XLEN-1:0]             cdb_val,
    output logic [SRC_W-1:0]            cdb_src
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    // Last-granted pointer starts at the top index so source 0 is searched first.
    localparam logic [SRC_W-1:0] RR_INIT  = SRC_W'(NUM_SRC - 1);

    logic [ID_WIDTH-1:0] id_mem_q  [NUM_SRC][FIFO_DEPTH];
    logic [ID_WIDTH-1:0] id_mem_d  [NUM_SRC][FIFO_DEPTH];
    logic [XLEN-1:0]     val_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [XLEN-1:0]     val_mem_d [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]    head_q [NUM_SRC];
    logic [PTR_W-1:0]    head_d [NUM_SRC];
    logic [PTR_W-1:0]    tail_q [NUM_SRC];
    logic [PTR_W-1:0]    tail_d [NUM_SRC];
    logic [CNT_W-1:0]    count_q [NUM_SRC];
    logic [CNT_W-1:0]    count_d [NUM_SRC];
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [ID_WIDTH-1:0] cdb_id_q, cdb_id_d;
    logic [XLEN-1:0]     cdb_val_q, cdb_val_d;
    logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;

    logic                grant_found;
    logic [SRC_W-1:0]    grant_idx;
    int                  cand;

    assign cdb_valid = cdb_valid_q;
    assign cdb_id    = cdb_id_q;
    assign cdb_val   = cdb_val_q;
    assign cdb_src   = cdb_src_q;

    // Ready depends only on registered occupancy plus rst/flush; a full FIFO never passes through.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count_q[i] != FULL_CNT) && !rst && !flush;
        end
    end

    // Round-robin search starting one past the last winner, first non-empty FIFO wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!grant_found && (count_q[SRC_W'(cand)] != '0)) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    // Next state: flush empties everything and suppresses grants, otherwise push/pop/broadcast.
    always_comb begin
        id_mem_d    = id_mem_q;
        val_mem_d   = val_mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_id_d    = cdb_id_q;
        cdb_val_d   = cdb_val_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head_d[i]  = '0;
                tail_d[i]  = '0;
                count_d[i] = '0;
            end
            cdb_valid_d = 1'b0;
            rr_ptr_d    = RR_INIT;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    id_mem_d[i][tail_q[i]]  = src_id[i*ID_WIDTH +: ID_WIDTH];
                    val_mem_d[i][tail_q[i]] = src_val[i*XLEN +: XLEN];
                    tail_d[i]               = tail_q[i] + 1'b1;
                end
                if (grant_found && (grant_idx == SRC_W'(i))) begin
                    head_d[i] = head_q[i] + 1'b1;
                end
                case ({src_valid[i] && src_ready[i], grant_found && (grant_idx == SRC_W'(i))})
                    2'b10:   count_d[i] = count_q[i] + 1'b1;
                    2'b01:   count_d[i] = count_q[i] - 1'b1;
                    default: count_d[i] = count_q[i];
                endcase
            end
            cdb_valid_d = grant_found;
            if (grant_found) begin
                cdb_id_d  = id_mem_q[grant_idx][head_q[grant_idx]];
                cdb_val_d = val_mem_q[grant_idx][head_q[grant_idx]];
                cdb_src_d = grant_idx;
                rr_ptr_d  = grant_idx;
            end
        end
    end

    // State register; rdy low freezes everything including reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            id_mem_q  <= id_mem_d;
            val_mem_q <= val_mem_d;
            if (rst) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    head_q[i]  <= '0;
                    tail_q[i]  <= '0;
                    count_q[i] <= '0;
                end
                rr_ptr_q    <= RR_INIT;
                cdb_valid_q <= 1'b0;
                cdb_id_q    <= '0;
                cdb_val_q   <= '0;
                cdb_src_q   <= '0;
            end else begin
                head_q      <= head_d;
                tail_q      <= tail_d;
                count_q     <= count_d;
                rr_ptr_q    <= rr_ptr_d;
                cdb_valid_q <= cdb_valid_d;
                cdb_id_q    <= cdb_id_d;
                cdb_val_q   <= cdb_val_d;
                cdb_src_q   <= cdb_src_d;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int XW = 32;
    localparam int D  = 2;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst, rdy, flush;
    logic [N-1:0]    src_valid;
    logic [N*IW-1:0] src_id;
    logic [N*XW-1:0] src_val;
    logic [N-1:0]    src_ready;
    logic            cdb_valid;
    logic [IW-1:0]   cdb_id;
    logic [XW-1:0]   cdb_val;
    logic [SW-1:0]   cdb_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.NUM_SRC(N), .ID_WIDTH(IW), .XLEN(XW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .src_valid(src_valid), .src_id(src_id), .src_val(src_val),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one queue per source, a last-winner index, and the last broadcast.
    typedef struct packed {
        logic [IW-1:0] id;
        logic [XW-1:0] val;
    } ent_t;

    ent_t          mq [N][$];
    int            m_rr;
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [XW-1:0] m_val;
    logic [SW-1:0] m_src;
    bit            m_init = 1'b0;

    always @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                for (int i = 0; i < N; i++) mq[i].delete();
                m_rr = N - 1; m_valid = 1'b0; m_id = '0; m_val = '0; m_src = '0;
                m_init = 1'b1;
            end else if (m_init) begin
                if (flush) begin
                    for (int i = 0; i < N; i++) mq[i].delete();
                    m_rr = N - 1; m_valid = 1'b0;
                end else begin
                    int   g;
                    bit   acc [N];
                    ent_t e;
                    g = -1;
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_rr + k) % N;
                        if (g < 0 && mq[c].size() > 0) g = c;
                    end
                    for (int i = 0; i < N; i++) acc[i] = src_valid[i] && (mq[i].size() < D);
                    if (g >= 0) begin
                        e = mq[g].pop_front();
                        m_valid = 1'b1; m_id = e.id; m_val = e.val; m_src = g[SW-1:0]; m_rr = g;
                    end else begin
                        m_valid = 1'b0;
                    end
                    for (int i = 0; i < N; i++)
                        if (acc[i]) mq[i].push_back({src_id[i*IW +: IW], src_val[i*XW +: XW]});
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic [N-1:0] er;
            for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D) && !rst && !flush;
            chk("cyc_src_ready", src_ready, er);
            chk("cyc_cdb_valid", cdb_valid, m_valid);
            chk("cyc_cdb_id", cdb_id, m_id);
            chk("cyc_cdb_val", cdb_val, m_val);
            chk("cyc_cdb_src", cdb_src, m_src);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input logic [IW-1:0] id, input logic [XW-1:0] val);
        src_valid[i]        = v;
        src_id[i*IW +: IW]  = id;
        src_val[i*XW +: XW] = val;
    endtask

    initial begin
        logic [IW-1:0] got [$];
        logic [IW-1:0] bp_ids [3];
        int            idx;
        bit            saw_block;
        bit            acc1;
        logic [IW-1:0] h_id;
        logic [XW-1:0] h_val;
        logic [SW-1:0] h_src;

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        src_valid = '0; src_id = '0; src_val = '0;
        tick(); tick();
        chk("rst_ready", src_ready, 0);
        chk("rst_valid", cdb_valid, 0);
        chk("rst_id", cdb_id, 0);
        chk("rst_val", cdb_val, 0);
        chk("rst_src", cdb_src, 0);
        rst = 1'b0; #1;
        chk("post_rst_ready", src_ready, 3'b111);

        // single push, one-cycle latency, one-cycle valid
        set_src(0, 1'b1, 4'd5, 32'h1234);
        tick(); src_valid = '0;
        chk("single_no_bypass", cdb_valid, 0);
        tick();
        chk("single_valid", cdb_valid, 1);
        chk("single_id", cdb_id, 5);
        chk("single_val", cdb_val, 32'h1234);
        chk("single_src", cdb_src, 0);
        tick();
        chk("single_drop", cdb_valid, 0);

        // round-robin from a fresh pointer
        flush = 1'b1; tick(); flush = 1'b0;
        set_src(0, 1'b1, 4'd1, 32'h11); set_src(1, 1'b1, 4'd2, 32'h22); set_src(2, 1'b1, 4'd3, 32'h33);
        tick();
        src_valid = '0; set_src(0, 1'b1, 4'd4, 32'h44);
        tick(); src_valid = '0;
        chk("rr0_id", cdb_id, 1); chk("rr0_src", cdb_src, 0);
        tick();
        chk("rr1_id", cdb_id, 2); chk("rr1_src", cdb_src, 1);
        tick();
        chk("rr2_id", cdb_id, 3); chk("rr2_src", cdb_src, 2);
        tick();
        chk("rr3_id", cdb_id, 4); chk("rr3_src", cdb_src, 0); chk("rr3_val", cdb_val, 32'h44);
        tick();
        chk("rr_idle", cdb_valid, 0);

        // backpressure on src1 while src0/src2 keep the bus busy; src1 granted last
        set_src(1, 1'b1, 4'd6, 32'h66); tick(); src_valid = '0; tick();
        bp_ids[0] = 4'd7; bp_ids[1] = 4'd8; bp_ids[2] = 4'd9;
        idx = 0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 3; cyc++) begin
            set_src(0, 1'b1, 4'd12, 32'hA000 + cyc);
            set_src(2, 1'b1, 4'd13, 32'hC000 + cyc);
            if (idx < 3) set_src(1, 1'b1, bp_ids[idx], 32'hB000 + idx);
            else         src_valid[1] = 1'b0;
            if (src_valid[1] && !src_ready[1]) saw_block = 1'b1;
            acc1 = src_valid[1] && src_ready[1];
            tick();
            if (acc1) idx++;
            if (cdb_valid && cdb_src == 2'd1) got.push_back(cdb_id);
        end
        src_valid = '0;
        chk("bp_count", got.size(), 3);
        for (int j = 0; j < 3; j++) if (j < got.size()) chk("bp_order", got[j], bp_ids[j]);
        chk("bp_blocked", saw_block, 1);
        repeat (8) tick();

        // flush with four pending entries and a live broadcast
        set_src(0, 1'b1, 4'd1, 32'h1); set_src(1, 1'b1, 4'd2, 32'h2); set_src(2, 1'b1, 4'd3, 32'h3);
        tick();
        src_valid = '0; set_src(0, 1'b1, 4'd4, 32'h4); set_src(2, 1'b1, 4'd5, 32'h5);
        tick(); src_valid = '0;
        chk("fl_pre_valid", cdb_valid, 1);
        flush = 1'b1; tick();
        chk("fl_valid", cdb_valid, 0);
        flush = 1'b0; #1;
        chk("fl_ready", src_ready, 3'b111);
        set_src(0, 1'b1, 4'hA, 32'hAA); set_src(1, 1'b1, 4'hB, 32'hBB); set_src(2, 1'b1, 4'hC, 32'hCC);
        tick(); src_valid = '0;
        chk("fl_no_stale", cdb_valid, 0);
        tick();
        chk("fl_first_valid", cdb_valid, 1);
        chk("fl_first_src", cdb_src, 0);
        chk("fl_first_id", cdb_id, 4'hA);

        // rdy low: freeze outputs, ignore pushes, then resume
        h_id = cdb_id; h_val = cdb_val; h_src = cdb_src;
        rdy = 1'b0;
        set_src(0, 1'b1, 4'hE, 32'hE0); set_src(1, 1'b1, 4'hE, 32'hE1); set_src(2, 1'b1, 4'hE, 32'hE2);
        repeat (3) begin
            tick();
            chk("hold_valid", cdb_valid, 1);
            chk("hold_id", cdb_id, h_id);
            chk("hold_val", cdb_val, h_val);
            chk("hold_src", cdb_src, h_src);
        end
        src_valid = '0; rdy = 1'b1;
        tick();
        chk("resume0_src", cdb_src, 1); chk("resume0_id", cdb_id, 4'hB);
        tick();
        chk("resume1_src", cdb_src, 2); chk("resume1_id", cdb_id, 4'hC);
        tick();
        chk("resume_idle", cdb_valid, 0);

        // randomized traffic with occasional flush, reset and stall
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            rdy       = ($urandom_range(0, 9) != 0);
            src_valid = N'($urandom);
            src_id    = (N*IW)'($urandom);
            src_val   = {$urandom, $urandom, $urandom};
            tick();
        end
        rst = 1'b0; flush = 1'b0; rdy = 1'b1; src_valid = '0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo back end. Several result producers compete for one broadcast bus: the ALU, the load path of the memory controller and the branch/jump unit. The bus drives `alu_*`/`mem_*`-style wakeup in the reservation station, the load-store buffer and the ROB. This block gives each producer a small FIFO, grants the bus round-robin to one non-empty FIFO per cycle, and drives a registered `cdb_valid/cdb_id/cdb_val` broadcast. Misprediction flush clears it.

## Interface
- `NUM_SRC`, default 3: number of producers (index 0 = ALU, 1 = load, 2 = branch unit).
- `ID_WIDTH`, default 4: ROB id width; equal to `ROB_SIZE_WIDTH`.
- `XLEN`, default 32: result width.
- `FIFO_DEPTH`, default 2: entries per source FIFO; must be a power of two ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high. Acts only on `clk` rising edges where `rdy`=1.
- `rdy` in 1: global clock enable. When 0, all state and outputs hold.
- `flush` in 1: misprediction flush from ROB.
- `src_valid` in NUM_SRC: producer i offers a result.
- `src_id` in NUM_SRC*ID_WIDTH: ROB id of producer i; packed with slice i at [i*ID_WIDTH +: ID_WIDTH].
- `src_val` in NUM_SRC*XLEN: result of producer i; packed the same way.
- `src_ready` out NUM_SRC: FIFO i can accept a result this cycle.
- `cdb_valid` out 1: broadcast valid this cycle.
- `cdb_id` out ID_WIDTH: ROB id being broadcast.
- `cdb_val` out XLEN: value being broadcast.
- `cdb_src` out clog2(NUM_SRC): index of the source that won the bus. Debug and ROB use.

## Operation
- Per-source FIFO: circular, FIFO_DEPTH entries of {id, val}, with head/tail pointers and count (0..FIFO_DEPTH).
- `src_ready[i]` = (count_i != FIFO_DEPTH) && !rst && !flush. This is combinational from registered state. There is no pass-through: a full FIFO is not ready even if it is popped this cycle.
- Push: `src_valid[i] && src_ready[i] && rdy` writes into FIFO i at the edge.
- Arbitration is combinational over FIFOs with count>0. It searches from index `rr_ptr+1` (modulo NUM_SRC) upward and takes the first non-empty FIFO as the grant `g`.
- On a grant, at the edge:
  - the head of FIFO g pops;
  - `cdb_valid`<=1, `cdb_id`/`cdb_val`<=head, `cdb_src`<=g;
  - `rr_ptr`<=g.
- With no grant: `cdb_valid`<=0, `cdb_id`/`cdb_val`/`cdb_src`/`rr_ptr` hold.
- A push and a pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
- Wrap-around: pointers increment modulo FIFO_DEPTH. Order within each source is strictly FIFO.
- Fairness: a non-empty FIFO is granted within NUM_SRC cycles.
- Flush (priority below rst, above everything else):
  - all counts and pointers go to 0;
  - `cdb_valid`<=0;
  - `rr_ptr`<=NUM_SRC-1;
  - pushes presented in the flush cycle are discarded;
  - no grant is issued.
- Reset values:
  - `cdb_valid`=0, `cdb_id`=0, `cdb_val`=0, `cdb_src`=0;
  - all FIFOs empty;
  - `rr_ptr`=NUM_SRC-1, so source 0 has first priority;
  - `src_ready`=0 while `rst` is high, and all 1 on the cycle after reset.
- `rdy`=0: no push, no pop, no flush/reset action; outputs hold (including `cdb_valid`=1 if it was 1).

## Timing
- Latency: a result accepted at edge E is broadcast at the earliest at edge E+1, and is visible in the cycle after E+1. There is no same-cycle bypass.
- Throughput: one broadcast per cycle total; one push per source per cycle.
- `cdb_*` are registered and valid for exactly one cycle per grant. Consumers sample them on the next edge.
- `src_ready` is a function of state only, so producers may use it combinationally without loops.
- Sustained rate: with FIFO_DEPTH=2 and one result per cycle from each of 3 sources, every FIFO fills within 3 cycles. `src_ready` then toggles so that each source gets exactly 1 push per 3 cycles.

## Test plan
- Reset then single push: src0 pushes id=5, val=0x1234 at edge 1. At edge 2, `cdb_valid`=1, id=5, val=0x1234, src=0. At edge 3, `cdb_valid`=0.
- Round-robin: all three sources push at the same edge (ids 1, 2, 3). Broadcasts come on consecutive cycles in order src0, src1, src2. A further push of id 4 by src0 then follows src2.
- Backpressure: src1 pushes ids 7, 8, 9 back-to-back while src0 and src2 hold the bus. `src_ready[1]` drops after 2 accepts; id 9 is accepted only after a pop. Broadcast order for src1 is 7, 8, 9, with no loss and no duplication.
- Simultaneous push/pop on a full FIFO: `src_ready` stays 0 that cycle, and count goes 2→1. The next cycle `src_ready`=1.
- Flush: 4 entries pending and `cdb_valid`=1, then `flush`. At the next edge `cdb_valid`=0 and every `src_ready`=1, and no stale id is ever broadcast. The first post-flush grant goes to src0.
- `rdy` low for 3 cycles with pending entries and `cdb_valid`=1: outputs frozen and pushes ignored. Once `rdy` returns, the arbitration sequence resumes unchanged.
